seq_div_16x8: RTL and testbench

- Iterative restoring unsigned divider. Inverse operation of the 8x8 → 16 multiplier datapath: 16-bit dividend ÷ 8-bit divisor → 8-bit quotient + 8-bit remainder.
- Produces one quotient bit per cycle behind a valid/ready handshake on both sides.
- Exact, not approximate. Serves as the reconstruction/checking partner for the approximate multiplier family, e.g. recovering an operand from a product.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 25 ++
 rtl/seq_div_16x8.sv | 138 +++++++++++++
 tb/tb_seq_div_16x8.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and sizing for the sequential restoring divider
package div_pkg;

    localparam int DIV_N  = 8;
    localparam int DIV_CW = $clog2(DIV_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division step: shift in a dividend bit, trial subtract
module div_step
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic [N-1:0] r,
    input  logic         bit_in,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] r_next,
    output logic         q_bit
);

    logic [N:0] t;
    logic [N:0] diff;

    // Trial subtraction on the N+1 bit shifted remainder; restore when it would go negative
    always_comb begin
        t      = {r, bit_in};
        diff   = t - {1'b0, divisor};
        q_bit  = (t >= {1'b0, divisor});
        r_next = q_bit ? diff[N-1:0] : t[N-1:0];
    end

endmodule

// File: rtl/seq_div_16x8.sv
// rtl/seq_div_16x8.sv - iterative 2N/N unsigned divider with valid/ready on both sides
module seq_div_16x8
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quot,
    output logic [N-1:0]   rem,
    output logic           ovf,
    output logic           dz
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    div_state_e  state_q, state_d;
    logic [N-1:0] r_q, r_d;
    logic [N-1:0] l_q, l_d;
    logic [N-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] quot_q, quot_d;
    logic [N-1:0] rem_q, rem_d;
    logic         ovf_q, ovf_d;
    logic         dz_q, dz_d;

    logic [N-1:0] step_r;
    logic         step_q;

    div_step #(.N(N)) u_step (
        .r       (r_q),
        .bit_in  (l_q[N-1]),
        .divisor (div_q),
        .r_next  (step_r),
        .q_bit   (step_q)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            l_q     <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            l_q     <= l_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state and datapath update; results only change when entering DONE
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        l_d     = l_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    div_d = divisor;
                    if (divisor == '0) begin
                        dz_d    = 1'b1;
                        ovf_d   = 1'b0;
                        quot_d  = '1;
                        rem_d   = dividend[N-1:0];
                        state_d = DONE;
                    end else if (dividend[2*N-1:N] >= divisor) begin
                        // Upper half already >= divisor: quotient needs more than N bits
                        ovf_d   = 1'b1;
                        dz_d    = 1'b0;
                        quot_d  = '1;
                        rem_d   = '1;
                        state_d = DONE;
                    end else begin
                        r_d     = dividend[2*N-1:N];
                        l_d     = dividend[N-1:0];
                        cnt_d   = CW'(N - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // L doubles as the dividend shift-out and the quotient shift-in register
                r_d = step_r;
                l_d = {l_q[N-2:0], step_q};
                if (cnt_q == '0) begin
                    quot_d  = {l_q[N-2:0], step_q};
                    rem_d   = step_r;
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_div_16x8.sv
// tb/tb_seq_div_16x8.sv - randomized self-checking bench for seq_div_16x8
module tb_seq_div_16x8;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] dividend  = '0;
    logic [7:0]  divisor   = '0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  quot;
    logic [7:0]  rem;
    logic        ovf;
    logic        dz;

    int n_checks = 0;
    int n_fail   = 0;

    seq_div_16x8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .ovf       (ovf),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, measure latency, optionally backpressure, then retire it
    task automatic run_op(input logic [15:0] dd, input logic [7:0] dv, input int hold);
        logic [15:0] q16;
        logic [7:0]  eq, er;
        logic        eo, ez;
        int          elat, lat, w;
        logic        any_valid;

        if (dv == 8'd0) begin
            eq = 8'hFF; er = dd[7:0]; eo = 1'b0; ez = 1'b1; elat = 1;
        end else if (dd[15:8] >= dv) begin
            eq = 8'hFF; er = 8'hFF; eo = 1'b1; ez = 1'b0; elat = 1;
        end else begin
            q16  = dd / {8'd0, dv};
            eq   = q16[7:0];
            q16  = dd % {8'd0, dv};
            er   = q16[7:0];
            eo   = 1'b0; ez = 1'b0; elat = 9;
        end

        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("idle_ready", 32'(in_ready), 32'd1);

        in_valid = 1'b1;
        dividend = dd;
        divisor  = dv;
        lat = 0;
        do begin
            tick();
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 40);
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        chk("latency", 32'(lat), 32'(elat));
        chk("quot", 32'(quot), 32'(eq));
        chk("rem", 32'(rem), 32'(er));
        chk("ovf", 32'(ovf), 32'(eo));
        chk("dz", 32'(dz), 32'(ez));
        if (!eo && !ez) begin
            chk("recon", 32'(quot) * 32'(dv) + 32'(rem), 32'(dd));
            chk("rem_lt_div", 32'(rem < dv), 32'd1);
        end

        // Stall the consumer while offering a competing operation that must be ignored
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
            tick();
            chk("hold_stable", {20'd0, quot, rem, ovf, dz, out_valid, in_ready},
                {20'd0, eq, er, eo, ez, 1'b1, 1'b0});
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("retire_valid", 32'(out_valid), 32'd0);
        chk("retire_ready", 32'(in_ready), 32'd1);
        if (hold > 0) begin
            any_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                any_valid = any_valid | out_valid;
            end
            chk("no_ghost_op", 32'(any_valid), 32'd0);
            chk("retained_quot", 32'(quot), 32'(eq));
        end
    endtask

    initial begin
        logic [15:0] dd;
        logic [7:0]  dv;
        logic        any_valid;

        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outs", {14'd0, quot, rem, ovf, dz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op(16'd1000, 8'd7, 0);
        run_op(16'd50000, 8'd200, 0);
        run_op(16'h00FF, 8'h01, 0);
        run_op(16'h1234, 8'h10, 0);
        run_op(16'h0055, 8'h00, 0);
        run_op(16'd1000, 8'd7, 20);

        // Abort an operation in the middle of its fourth step
        in_valid = 1'b1;
        dividend = 16'd40000;
        divisor  = 8'd199;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_outs", {14'd0, quot, rem, ovf, dz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            any_valid = any_valid | out_valid;
        end
        chk("abort_silent", 32'(any_valid), 32'd0);
        run_op(16'h0100, 8'h03, 0);

        for (int i = 0; i < 2500; i++) begin
            dv = 8'($urandom_range(1, 255));
            dd = {8'($urandom_range(0, 32'(dv) - 1)), 8'($urandom)};
            run_op(dd, dv, $urandom_range(0, 3));
        end
        for (int i = 0; i < 800; i++) begin
            dd = 16'($urandom);
            dv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_op(dd, dv, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
